// File: rtl/mem_stage_access_unit.sv
// Memory-stage data-bus access unit: turns M-stage load/store controls into a
// req/ack bus transaction with byte-lane steering and load extension.
module mem_stage_access_unit #(
  parameter int WIDTH_32 = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemtoReg_M,
  input  logic                MemWrite_M,
  input  logic [3:0]          ByteControl_M,
  input  logic [WIDTH_32-1:0] ALU_result_M,
  input  logic [WIDTH_32-1:0] WriteData_M,
  input  logic                hold_M,
  output logic                stall_M,
  output logic [WIDTH_32-1:0] ReadData_M,
  output logic                misaligned_M,
  output logic                bus_err_M,
  output logic                dbus_req,
  output logic                dbus_we,
  output logic [WIDTH_32-1:0] dbus_addr,
  output logic [3:0]          dbus_be,
  output logic [WIDTH_32-1:0] dbus_wdata,
  input  logic                dbus_ack,
  input  logic [WIDTH_32-1:0] dbus_rdata,
  output logic [1:0]          o_state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, w_next;
  logic [7:0]          r_cnt;
  logic                r_req, r_we, r_err;
  logic [WIDTH_32-1:0] r_addr, r_wdata, r_rdata;
  logic [3:0]          r_be;
  logic [1:0]          r_lane;
  logic                r_is_byte, r_is_half, r_unsigned;

  logic                w_access, w_is_byte, w_is_half, w_is_word, w_misaligned;
  logic                w_issue, w_stall, w_unused;
  logic [3:0]          w_be;
  logic [WIDTH_32-1:0] w_wdata, w_load_data;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  assign w_access  = MemtoReg_M | MemWrite_M;
  assign w_is_byte = (ByteControl_M[1:0] == 2'b10);
  assign w_is_half = (ByteControl_M[1:0] == 2'b01);
  assign w_is_word = !w_is_byte && !w_is_half;
  assign w_unused  = ByteControl_M[3];

  assign w_misaligned = w_access &
                        ((w_is_word & (ALU_result_M[1:0] != 2'b00)) |
                         (w_is_half & ALU_result_M[0]));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_M;
    if (w_is_byte) begin
      w_be    = 4'b0001 << ALU_result_M[1:0];
      w_wdata = {4{WriteData_M[7:0]}};
    end else if (w_is_half) begin
      w_be    = ALU_result_M[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{WriteData_M[15:0]}};
    end
  end

  // Extraction uses the lane/size latched at issue, so M-stage inputs may move during REQ.
  always_comb begin
    w_byte = dbus_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      2'd3:    w_byte = dbus_rdata[31:24];
      default: w_byte = dbus_rdata[7:0];
    endcase
    w_half = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    w_load_data = dbus_rdata;
    if (r_is_byte)
      w_load_data = {{(WIDTH_32-8){w_byte[7] & !r_unsigned}}, w_byte};
    else if (r_is_half)
      w_load_data = {{(WIDTH_32-16){w_half[15] & !r_unsigned}}, w_half};
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access & !w_misaligned;
        if (w_stall) begin
          w_next  = S_REQ;
          w_issue = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (dbus_ack || (r_cnt == CNT_LAST)) w_next = S_DONE;
      end
      S_DONE: begin
        if (!hold_M) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_be       <= 4'b0000;
      r_lane     <= 2'b00;
      r_is_byte  <= 1'b0;
      r_is_half  <= 1'b0;
      r_unsigned <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_addr     <= {ALU_result_M[WIDTH_32-1:2], 2'b00};
        r_be       <= w_be;
        r_we       <= MemWrite_M & !MemtoReg_M;
        r_wdata    <= w_wdata;
        r_lane     <= ALU_result_M[1:0];
        r_is_byte  <= w_is_byte;
        r_is_half  <= w_is_half;
        r_unsigned <= ByteControl_M[2];
        r_cnt      <= 8'd0;
        r_req      <= 1'b1;
      end
      if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 8'd1;
        if (dbus_ack) begin
          r_rdata <= r_we ? '0 : w_load_data;
          r_req   <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
          r_req   <= 1'b0;
        end
      end
      if ((r_state == S_DONE) && !hold_M) r_err <= 1'b0;
    end
  end

  assign stall_M      = w_stall;
  assign misaligned_M = w_misaligned;
  assign ReadData_M   = r_rdata;
  assign bus_err_M    = r_err;
  assign dbus_req     = r_req;
  assign dbus_we      = r_we;
  assign dbus_addr    = r_addr;
  assign dbus_be      = r_be;
  assign dbus_wdata   = r_wdata;
  assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed cases from the access
// rules plus randomized aligned accesses, scoreboarded on completion.
module tb_mem_stage_access_unit;

  localparam int TIMEOUT = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoReg_M, MemWrite_M, hold_M;
  logic [3:0]  ByteControl_M;
  logic [31:0] ALU_result_M, WriteData_M;
  logic        stall_M, misaligned_M, bus_err_M;
  logic [31:0] ReadData_M;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic [1:0]  state_dbg;

  logic [32:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  mem_stage_access_unit #(.WIDTH_32(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_M(MemtoReg_M), .MemWrite_M(MemWrite_M), .ByteControl_M(ByteControl_M),
    .ALU_result_M(ALU_result_M), .WriteData_M(WriteData_M), .hold_M(hold_M),
    .stall_M(stall_M), .ReadData_M(ReadData_M), .misaligned_M(misaligned_M),
    .bus_err_M(bus_err_M), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .o_state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [3:0] bc, input logic [31:0] a);
    if (bc[1:0] == 2'b10) return 4'b0001 << a[1:0];
    if (bc[1:0] == 2'b01) return 4'b0011 << {a[1], 1'b0};
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] bc, input logic [31:0] d);
    if (bc[1:0] == 2'b10) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (bc[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] bc, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a[1:0]);
    if (bc[1:0] == 2'b10) begin
      v = v & 32'h0000_00FF;
      if (!bc[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (bc[1:0] == 2'b01) begin
      v = v & 32'h0000_FFFF;
      if (!bc[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    MemtoReg_M = 1'b0; MemWrite_M = 1'b0; hold_M = 1'b0; ByteControl_M = 4'b0000;
    ALU_result_M = 32'h0; WriteData_M = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
  // ack_at < 0 means the bus never acknowledges.
  task automatic run_access(input logic ld, input logic st, input logic [3:0] bc,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_at, input int hold_cyc);
    logic        is_st, exp_err;
    int          exp_n, n;
    logic [32:0] e;
    is_st   = st & !ld;
    exp_err = (ack_at < 0) || (ack_at >= TIMEOUT);
    exp_n   = exp_err ? TIMEOUT : ack_at + 1;
    exp_q.push_back({exp_err, (exp_err || is_st) ? 32'h0 : model_load(bc, addr, rd)});
    MemtoReg_M = ld; MemWrite_M = st; ByteControl_M = bc;
    ALU_result_M = addr; WriteData_M = wd; hold_M = (hold_cyc > 0);
    #1;
    check("idle_stall", stall_M, 1'b1);
    check("idle_misaligned", misaligned_M, 1'b0);
    @(posedge clk);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!dbus_req) break;
      n++;
      check("req_stall", stall_M, 1'b1);
      check("req_addr", dbus_addr, {addr[31:2], 2'b00});
      check("req_be", dbus_be, model_be(bc, addr));
      check("req_we", dbus_we, is_st);
      if (is_st) check("req_wdata", dbus_wdata, model_wdata(bc, wd));
      dbus_ack   = (n - 1 == ack_at);
      dbus_rdata = rd;
      ALU_result_M = $urandom;
      WriteData_M  = $urandom;
    end
    dbus_ack = 1'b0;
    check("req_cycles", n, exp_n);
    check("done_state", state_dbg, ST_DONE);
    check("done_stall", stall_M, 1'b0);
    if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check("rdata", ReadData_M, e[31:0]);
      check("bus_err", bus_err_M, e[32]);
    end
    e = {bus_err_M, ReadData_M};
    for (int i = 1; i < hold_cyc; i++) begin
      @(negedge clk);
      check("hold_state", state_dbg, ST_DONE);
      check("hold_req", dbus_req, 1'b0);
      check("hold_rdata", ReadData_M, e[31:0]);
      check("hold_err", bus_err_M, e[32]);
    end
    hold_M = 1'b0;
    @(negedge clk);
    check("exit_state", state_dbg, ST_IDLE);
    check("exit_err", bus_err_M, 1'b0);
    MemtoReg_M = 1'b0; MemWrite_M = 1'b0;
  endtask

  initial begin
    int kind, ack_at;
    logic [3:0]  bc;
    logic [31:0] a;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_req", dbus_req, 1'b0);
    check("rst_we", dbus_we, 1'b0);
    check("rst_addr", dbus_addr, 32'h0);
    check("rst_be", dbus_be, 4'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    check("rst_rdata", ReadData_M, 32'h0);
    check("rst_err", bus_err_M, 1'b0);
    check("rst_stall", stall_M, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // sw, lb, lbu, sh, lh, lw/lhu
    run_access(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_access(1'b1, 1'b0, 4'b0010, 32'h0000_0013, 32'h0, 32'h80AA_BBCC, 0, 0);
    run_access(1'b1, 1'b0, 4'b0110, 32'h0000_0013, 32'h0, 32'h80AA_BBCC, 1, 0);
    run_access(1'b0, 1'b1, 4'b0001, 32'h0000_000E, 32'h0000_1234, 32'h0, 0, 0);
    run_access(1'b1, 1'b0, 4'b0001, 32'h0000_000E, 32'h0, 32'h8001_0000, 0, 0);
    run_access(1'b1, 1'b0, 4'b0101, 32'h0000_0020, 32'h0, 32'h1234_8765, 2, 0);
    run_access(1'b1, 1'b1, 4'b1011, 32'h0000_0040, 32'h5555_5555, 32'hCAFE_F00D, 0, 0);
    // timeout, then ack landing on the timeout cycle, then a held DONE
    run_access(1'b1, 1'b0, 4'b0000, 32'h0000_0080, 32'h0, 32'h1111_2222, -1, 0);
    run_access(1'b1, 1'b0, 4'b0000, 32'h0000_0084, 32'h0, 32'h3333_4444, TIMEOUT - 1, 0);
    run_access(1'b1, 1'b0, 4'b0000, 32'h0000_0088, 32'h0, 32'h9ABC_DEF0, 0, 3);
    run_access(1'b0, 1'b1, 4'b0000, 32'h0000_008C, 32'h7777_8888, 32'h0, -1, 2);

    // misaligned lw and sh never reach the bus
    MemtoReg_M = 1'b1; ByteControl_M = 4'b0000; ALU_result_M = 32'h0000_0006;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mis_flag", misaligned_M, 1'b1);
      check("mis_stall", stall_M, 1'b0);
      @(negedge clk);
      check("mis_req", dbus_req, 1'b0);
      check("mis_state", state_dbg, ST_IDLE);
    end
    MemtoReg_M = 1'b0; MemWrite_M = 1'b1; ByteControl_M = 4'b0001; ALU_result_M = 32'h0000_0003;
    #1;
    check("mis_half", misaligned_M, 1'b1);
    @(negedge clk);
    check("mis_half_req", dbus_req, 1'b0);
    MemWrite_M = 1'b0;
    @(negedge clk);

    // reset during REQ; a late ack afterwards is ignored
    MemtoReg_M = 1'b1; ByteControl_M = 4'b0000; ALU_result_M = 32'h0000_0100;
    @(negedge clk);
    check("rreq_req", dbus_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rreq_req_after", dbus_req, 1'b0);
    check("rreq_state", state_dbg, ST_IDLE);
    check("rreq_rdata", ReadData_M, 32'h0);
    rst_n = 1'b1; MemtoReg_M = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dbus_ack = 1'b0;
    check("late_ack_req", dbus_req, 1'b0);
    check("late_ack_state", state_dbg, ST_IDLE);
    check("late_ack_rdata", ReadData_M, 32'h0);

    // randomized aligned traffic
    for (int t = 0; t < 24; t++) begin
      kind   = $urandom_range(0, 2);
      ack_at = $urandom_range(0, 3);
      bc     = 4'($urandom_range(0, 15));
      a      = $urandom;
      if (bc[1:0] == 2'b01) a[0] = 1'b0;
      else if (bc[1:0] != 2'b10) a[1:0] = 2'b00;
      run_access(kind != 1, kind != 0, bc, a, $urandom, $urandom, ack_at,
                 $urandom_range(0, 2));
    end

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS pipeline.
- Turns MemtoReg_M/MemWrite_M/ByteControl_M/ALU_result_M/WriteData_M into a req/ack data-bus transaction with byte-lane steering.
- Returns sign/zero-extended load data toward MEM/WB.
- Drives stall_M back to the hazard unit, which deasserts EN on upstream pipeline registers while an access is outstanding.

Parameters:
- WIDTH_32, 32, datapath/address width.
- TIMEOUT, 255, max cycles to wait for dbus_ack before forcing a bus error (8-bit counter; legal 1..255).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- MemtoReg_M  in  1  load in M stage.
- MemWrite_M  in  1  store in M stage.
- ByteControl_M  in  4  [1:0] size (00 word, 01 half, 10 byte, 11 treated as word); [2] 1 = unsigned load; [3] ignored.
- ALU_result_M  in  32  effective byte address.
- WriteData_M  in  32  store data, right-aligned.
- hold_M  in  1  downstream freeze; M-stage instruction will not advance this cycle.
- stall_M  out  1  upstream freeze request.
- ReadData_M  out  32  extended load data.
- misaligned_M  out  1  address-error flag, combinational.
- bus_err_M  out  1  timeout flag for the current access.
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address: {ALU_result_M[31:2], 2'b00}.
- dbus_be  out  4  byte enables, little-endian.
- dbus_wdata  out  32  lane-steered write data.
- dbus_ack  in  1  transfer complete; valid only while dbus_req = 1.
- dbus_rdata  in  32  read word, valid with dbus_ack.

Behaviour:
- access = MemtoReg_M | MemWrite_M. Both high is treated as a load.
- misaligned_M = access & ((size == word & addr[1:0] != 0) | (size == half & addr[0] != 0)).
  - A misaligned access never issues a bus request and never stalls.
- Lane steering:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
  - word: be = 1111; wdata = WriteData.
  - Loads drive be per size as well; dbus_we = 0.
- Load extract: select the lane by addr[1:0] and size. Sign-extend unless ByteControl_M[2] = 1, then zero-extend.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - stall_M = access & !misaligned_M.
    - If so, latch dbus_addr/be/we/wdata, load the timeout counter with 0, and go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - dbus_req = 1; stall_M = 1; bus outputs held stable.
    - Counter increments each cycle.
    - On dbus_ack: capture the extended dbus_rdata (0 for stores) into ReadData_M, and go to DONE.
    - If counter == TIMEOUT - 1 without ack: ReadData_M = 0, set bus_err_M, and go to DONE.
    - Ack has priority over timeout when both occur in the same cycle.
  - DONE:
    - dbus_req = 0; stall_M = 0; ReadData_M and bus_err_M held.
    - If hold_M = 1, stay in DONE (no re-issue).
    - Else go to IDLE and clear bus_err_M.
- Minimum latency with ack in the first REQ cycle: 3 cycles in M (IDLE, REQ, DONE), with stall_M high for 2 of them.
- dbus_ack outside REQ is ignored.
- Inputs may change while in REQ/DONE; the latched bus fields do not.
- Reset values, applied at the next edge even mid-transaction:
  - state = IDLE; dbus_req = 0; dbus_we = 0; dbus_addr = 0; dbus_be = 0; dbus_wdata = 0; ReadData_M = 0; bus_err_M = 0; counter = 0.
  - stall_M/misaligned_M follow inputs combinationally once in IDLE.
  - A late ack is ignored.

Test Plan:
- Aligned sw, addr 0x0000_0010, data 0xDEADBEEF, ack on first REQ cycle -> dbus_req 1 for one cycle, be = 1111, addr = 0x10, wdata = 0xDEADBEEF, we = 1; stall_M high 2 cycles then low.
- lb, addr 0x13, ack with rdata 0x80AA_BBCC, ByteControl = 0010 -> ReadData_M = 0xFFFF_FF80; same with ByteControl = 0110 (lbu) -> 0x0000_0080.
- sh, addr 0x0E, data 0x0000_1234 -> be = 1100, wdata = 0x1234_1234; lh addr 0x0E with rdata 0x8001_0000 -> ReadData_M = 0xFFFF_8001.
- lw, addr 0x06 -> misaligned_M = 1, stall_M = 0, dbus_req never asserted, state stays IDLE.
- TIMEOUT = 4, no ack -> dbus_req high exactly 4 cycles, then DONE with bus_err_M = 1, ReadData_M = 0; bus_err_M clears on leaving DONE.
- Mixed cases:
  - hold_M = 1 in DONE for 3 cycles -> no second request, ReadData_M stable.
  - rst_n low during REQ -> dbus_req = 0 next cycle; ack the following cycle is ignored; ReadData_M = 0.
